// File: rtl/main_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its store buffer.
// Store-buffer entries carry a full 30-bit word index; only the low bits address the array.
package main_mem_responder_pkg;

    typedef struct packed {
        logic [29:0] widx;
        logic [31:0] dat;
    } sb_entry_t;

    localparam int SB_WIDX_W = 30;
    localparam int SB_DAT_W  = 32;

    // Pointer width for a power-of-two buffer; never narrower than one bit.
    function automatic int sb_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/main_mem_store_buf.sv
// Store buffer: FIFO of pending stores with combinational newest-match lookup for read bypass.
// Latency: push/pop commit at the clock edge; lookup sees only entries present before the edge.
// Backpressure: none toward the core; a push while full with no pop is refused and flagged on o_drop.
module main_mem_store_buf
    import main_mem_responder_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [29:0] i_push_widx,
    input  logic [31:0] i_push_dat,
    input  logic        i_pop,
    input  logic [29:0] i_lookup_widx,
    output logic        o_hit,
    output logic [31:0] o_hit_dat,
    output logic [29:0] o_head_widx,
    output logic [31:0] o_head_dat,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_drop
);
    localparam int IDX_W = sb_idx_w(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    sb_entry_t        r_mem [SB_DEPTH];
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(SB_DEPTH));
    assign o_empty = (r_count == '0);

    // A pop frees a slot in the same cycle, so a push into a full buffer is fine when draining.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);
    assign o_drop = i_push & o_full & ~w_pop;

    assign o_head_widx = r_mem[r_rd_ptr].widx;
    assign o_head_dat  = r_mem[r_rd_ptr].dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + IDX_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{widx: i_push_widx, dat: i_push_dat};
        end
    end

    // Scan oldest to newest so the last match (the newest store) wins.
    always_comb begin
        logic [IDX_W-1:0] w_slot;
        o_hit     = 1'b0;
        o_hit_dat = '0;
        w_slot    = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_slot = r_rd_ptr + IDX_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem[w_slot].widx == i_lookup_widx)) begin
                o_hit     = 1'b1;
                o_hit_dat = r_mem[w_slot].dat;
            end
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Data-memory responder: word array behind a non-blocking store buffer; optional MAIN_MEM_PERF_EN counters.
// Latency: reads combinational from mem_addr with store bypass; stores and loader writes commit at the edge.
// Backpressure: none; loader wins the write port and stalls drain, a store arriving full with no drain is dropped (sb_ovf).
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int MAIN_MEM_BYTE_ADD_W = 8,
    parameter int SB_DEPTH            = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_cs,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dat_in,
    output logic [31:0] mem_dat_out,
    input  logic        ld_wen,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_dat,
    output logic        sb_full,
    output logic        sb_ovf
`ifdef MAIN_MEM_PERF_EN
    ,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_byp_cnt
`endif
);
    localparam int AW    = MAIN_MEM_BYTE_ADD_W - 2;
    localparam int DEPTH = 1 << AW;

    logic [31:0]   r_array [DEPTH];
    logic          r_sb_ovf;

    logic [AW-1:0] w_mem_aidx;
    logic [AW-1:0] w_ld_aidx;
    logic [29:0]   w_mem_widx;
    logic          w_store;
    logic          w_read;
    logic          w_pop_req;
    logic          w_drain;
    logic          w_hit;
    logic [31:0]   w_hit_dat;
    logic [29:0]   w_head_widx;
    logic [31:0]   w_head_dat;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [31:0]   w_rd_dat;

    assign w_mem_aidx = mem_addr[MAIN_MEM_BYTE_ADD_W-1:2];
    assign w_ld_aidx  = ld_addr[MAIN_MEM_BYTE_ADD_W-1:2];
    assign w_mem_widx = 30'(w_mem_aidx);
    assign w_store    = mem_cs & mem_wen;
    assign w_read     = mem_cs & ~mem_wen;

    // Reset must not let the oldest entry slip into the array on the way out.
    assign w_pop_req  = rst_n & ~ld_wen;
    assign w_drain    = w_pop_req & ~w_empty;

    main_mem_store_buf #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_store),
        .i_push_widx   (w_mem_widx),
        .i_push_dat    (mem_dat_in),
        .i_pop         (w_pop_req),
        .i_lookup_widx (w_mem_widx),
        .o_hit         (w_hit),
        .o_hit_dat     (w_hit_dat),
        .o_head_widx   (w_head_widx),
        .o_head_dat    (w_head_dat),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_drop        (w_drop)
    );

    // Loader is a backdoor: it never waits, and older buffered stores to the same word land after it.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            r_array[w_ld_aidx] <= ld_dat;
        end else if (w_drain) begin
            r_array[w_head_widx[AW-1:0]] <= w_head_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb_ovf <= 1'b0;
        end else if (w_drop) begin
            r_sb_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_rd_dat = '0;
        if (mem_cs) begin
            w_rd_dat = w_hit ? w_hit_dat : r_array[w_mem_aidx];
        end
    end

    assign mem_dat_out = w_rd_dat;
    assign sb_full     = w_full;
    assign sb_ovf      = r_sb_ovf;

`ifdef MAIN_MEM_PERF_EN
    logic [31:0] r_perf_rd_cnt;
    logic [31:0] r_perf_wr_cnt;
    logic [31:0] r_perf_byp_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_rd_cnt  <= '0;
            r_perf_wr_cnt  <= '0;
            r_perf_byp_cnt <= '0;
        end else begin
            if (w_read && (r_perf_rd_cnt != '1)) begin
                r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
            end
            if (w_store && !w_drop && (r_perf_wr_cnt != '1)) begin
                r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
            end
            if (w_read && w_hit && (r_perf_byp_cnt != '1)) begin
                r_perf_byp_cnt <= r_perf_byp_cnt + 32'd1;
            end
        end
    end

    assign perf_rd_cnt  = r_perf_rd_cnt;
    assign perf_wr_cnt  = r_perf_wr_cnt;
    assign perf_byp_cnt = r_perf_byp_cnt;
`endif

    logic w_unused;
    assign w_unused = ^{mem_addr[31:MAIN_MEM_BYTE_ADD_W], mem_addr[1:0],
                        ld_addr[31:MAIN_MEM_BYTE_ADD_W], ld_addr[1:0],
                        w_head_widx[29:AW]};

endmodule
